instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory loader, the counterpart of the main control decoder. It accepts symbolic instruction commands over a valid/ready handshake and encodes them into 32-bit machine words. Supported classes are LOAD, STORE, REG, BRANCH, IMM and JUMP. It writes the words to consecutive instruction-memory locations from word 0, so test programs and boot code are built on-chip ahead of the single-cycle core.

---
 rtl/instr_encoder.sv | 178 +++++++++++++++++
 tb/tb_instr_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder and instruction-memory loader.
// Captures symbolic commands over a valid/ready handshake, encodes them into
// 32-bit machine words and writes them to consecutive words from address 0.
//
// state | meaning
// IDLE  | ready for a command; fields captured on valid&ready
// ENC   | encode captured fields into imem_wdata, or flag an illegal class
// WR    | drive the write strobe at the write pointer, then advance
// DONE  | program complete or memory full; wait for clear
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_class,
    input  logic [2:0]        cmd_funct3,
    input  logic              cmd_funct7b5,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [20:0]       cmd_imm,
    input  logic              cmd_last,
    input  logic              clear,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] CLS_LOAD   = 3'd0;
    localparam logic [2:0] CLS_STORE  = 3'd1;
    localparam logic [2:0] CLS_REG    = 3'd2;
    localparam logic [2:0] CLS_BRANCH = 3'd3;
    localparam logic [2:0] CLS_IMM    = 3'd4;
    localparam logic [2:0] CLS_JUMP   = 3'd5;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JUMP   = 7'b1101111;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

    state_t state_q, state_nxt;

    logic [2:0]  cls_q;
    logic [2:0]  f3_q;
    logic        b5_q;
    logic [4:0]  rd_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [20:0] imm_q;
    logic        last_q;

    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              error_q;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              accept;
    logic              ptr_full;

    assign accept   = (state_q == IDLE) && cmd_valid;
    assign ptr_full = (count_q[ADDR_W-1:0] == PTR_LAST);

    // Pure field assembly from the captured command; shifts by immediate carry funct7b5.
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (cls_q)
            CLS_LOAD:   enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_LOAD};
            CLS_STORE:  enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_STORE};
            CLS_REG:    enc_word = {1'b0, b5_q, 5'b00000, rs2_q, rs1_q, f3_q, rd_q, OP_REG};
            CLS_BRANCH: enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                                    imm_q[4:1], imm_q[11], OP_BRANCH};
            CLS_IMM: begin
                if (f3_q == 3'b001 || f3_q == 3'b101)
                    enc_word = {1'b0, b5_q, 5'b00000, imm_q[4:0], rs1_q, f3_q, rd_q, OP_IMM};
                else
                    enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_IMM};
            end
            CLS_JUMP:   enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                                    rd_q, OP_JUMP};
            default:    enc_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_nxt;
    end

    // Next-state logic; an illegal command never reaches WR, so cmd_last on it is moot.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (cmd_valid) state_nxt = ENC;
            ENC:  state_nxt = enc_legal ? WR : IDLE;
            WR:   state_nxt = (last_q || ptr_full) ? DONE : IDLE;
            DONE: if (clear) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture; only on a completed handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            cls_q  <= 3'd0;
            f3_q   <= 3'd0;
            b5_q   <= 1'b0;
            rd_q   <= 5'd0;
            rs1_q  <= 5'd0;
            rs2_q  <= 5'd0;
            imm_q  <= 21'd0;
            last_q <= 1'b0;
        end else if (accept) begin
            cls_q  <= cmd_class;
            f3_q   <= cmd_funct3;
            b5_q   <= cmd_funct7b5;
            rd_q   <= cmd_rd;
            rs1_q  <= cmd_rs1;
            rs2_q  <= cmd_rs2;
            imm_q  <= cmd_imm;
            last_q <= cmd_last;
        end
    end

    // Encoded word, write count/pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_q <= 32'h0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                ENC: begin
                    if (enc_legal) wdata_q <= enc_word;
                    else           error_q <= 1'b1;
                end
                WR:   count_q <= count_q + CNT_ONE;
                DONE: begin
                    if (clear) begin
                        count_q <= '0;
                        error_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // The write pointer is the low bits of count; full leaves count at 2^ADDR_W.
    assign cmd_ready  = (state_q == IDLE);
    assign imem_we    = (state_q == WR);
    assign done       = (state_q == DONE);
    assign imem_addr  = count_q[ADDR_W-1:0];
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign error      = error_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a 64-word instance for encoding and
// handshake checks, and a 4-word instance for the memory-full path.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic        sel_small = 1'b0;
    logic        clear_b = 1'b0;
    logic        clear_s = 1'b0;
    logic [2:0]  cmd_class = '0;
    logic [2:0]  cmd_funct3 = '0;
    logic        cmd_funct7b5 = 1'b0;
    logic [4:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [20:0] cmd_imm = '0;
    logic        cmd_last = 1'b0;

    logic        ready_b, we_b, done_b, error_b;
    logic [5:0]  addr_b;
    logic [31:0] wdata_b;
    logic [6:0]  count_b;
    logic        ready_s, we_s, done_s, error_s;
    logic [1:0]  addr_s;
    logic [31:0] wdata_s;
    logic [2:0]  count_s;

    logic        valid_b, valid_s;
    logic        o_ready, o_we, o_done, o_error;
    logic [31:0] o_addr, o_wdata, o_count;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    assign valid_b = valid & ~sel_small;
    assign valid_s = valid & sel_small;
    assign o_ready = sel_small ? ready_s : ready_b;
    assign o_we    = sel_small ? we_s    : we_b;
    assign o_done  = sel_small ? done_s  : done_b;
    assign o_error = sel_small ? error_s : error_b;
    assign o_addr  = sel_small ? {30'd0, addr_s}  : {26'd0, addr_b};
    assign o_wdata = sel_small ? wdata_s : wdata_b;
    assign o_count = sel_small ? {29'd0, count_s} : {25'd0, count_b};

    instr_encoder #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(valid_b), .cmd_ready(ready_b),
        .cmd_class(cmd_class), .cmd_funct3(cmd_funct3), .cmd_funct7b5(cmd_funct7b5),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last), .clear(clear_b),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .count(count_b), .done(done_b), .error(error_b)
    );

    instr_encoder #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .cmd_valid(valid_s), .cmd_ready(ready_s),
        .cmd_class(cmd_class), .cmd_funct3(cmd_funct3), .cmd_funct7b5(cmd_funct7b5),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .cmd_last(cmd_last), .clear(clear_s),
        .imem_we(we_s), .imem_addr(addr_s), .imem_wdata(wdata_s),
        .count(count_s), .done(done_s), .error(error_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one command and follows it through ENC, WR and back.
    // cmd_valid is left high so back-to-back calls form a stream.
    task automatic do_cmd(input string tag, input logic [2:0] cls, input logic [2:0] f3,
                          input logic b5, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [20:0] imm, input logic last,
                          input logic [31:0] exp_addr, input logic [31:0] exp_data,
                          input logic exp_rdy);
        int n;
        cmd_class = cls; cmd_funct3 = f3; cmd_funct7b5 = b5;
        cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_last = last;
        valid = 1'b1;
        n = 0;
        while (!o_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_ready_wait"}, {31'd0, o_ready}, 32'd1);
        tick();
        check_eq({tag, "_enc_we"}, {31'd0, o_we}, 32'd0);
        check_eq({tag, "_enc_ready"}, {31'd0, o_ready}, 32'd0);
        tick();
        check_eq({tag, "_wr_we"}, {31'd0, o_we}, 32'd1);
        check_eq({tag, "_wr_addr"}, o_addr, exp_addr);
        check_eq({tag, "_wr_data"}, o_wdata, exp_data);
        tick();
        check_eq({tag, "_we_drop"}, {31'd0, o_we}, 32'd0);
        check_eq({tag, "_count"}, o_count, exp_addr + 32'd1);
        check_eq({tag, "_ready_after"}, {31'd0, o_ready}, {31'd0, exp_rdy});
        check_eq({tag, "_done_after"}, {31'd0, o_done}, {31'd0, ~exp_rdy});
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;

        check_eq("rst_ready", {31'd0, o_ready}, 32'd1);
        check_eq("rst_we",    {31'd0, o_we},    32'd0);
        check_eq("rst_addr",  o_addr,  32'd0);
        check_eq("rst_wdata", o_wdata, 32'd0);
        check_eq("rst_count", o_count, 32'd0);
        check_eq("rst_done",  {31'd0, o_done},  32'd0);
        check_eq("rst_error", {31'd0, o_error}, 32'd0);

        // first command, then idle a cycle to prove no duplicate acceptance
        do_cmd("imm_addi", 3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0,
               32'd0, 32'h00500093, 1'b1);
        valid = 1'b0;
        tick();
        tick();
        check_eq("idle_count", o_count, 32'd1);
        check_eq("idle_we", {31'd0, o_we}, 32'd0);

        // streamed commands with cmd_valid held high
        do_cmd("load", 3'd0, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, 21'd8, 1'b0,
               32'd1, 32'h0080A103, 1'b1);
        do_cmd("store", 3'd1, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 21'd4, 1'b0,
               32'd2, 32'h0020A223, 1'b1);
        do_cmd("reg_add", 3'd2, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0,
               32'd3, 32'h002081B3, 1'b1);
        do_cmd("reg_sub", 3'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0,
               32'd4, 32'h402081B3, 1'b1);
        do_cmd("imm_srai", 3'd4, 3'b101, 1'b1, 5'd1, 5'd1, 5'd0, 21'd3, 1'b0,
               32'd5, 32'h4030D093, 1'b1);
        do_cmd("branch", 3'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFFC, 1'b0,
               32'd6, 32'hFE208EE3, 1'b1);

        // illegal class carrying cmd_last: dropped, error set, no DONE
        cmd_class = 3'd7; cmd_last = 1'b1;
        tick();
        valid = 1'b0;
        check_eq("ill_enc_we", {31'd0, o_we}, 32'd0);
        tick();
        check_eq("ill_we",    {31'd0, o_we},    32'd0);
        check_eq("ill_error", {31'd0, o_error}, 32'd1);
        check_eq("ill_count", o_count, 32'd7);
        check_eq("ill_done",  {31'd0, o_done},  32'd0);
        check_eq("ill_ready", {31'd0, o_ready}, 32'd1);
        tick();
        check_eq("ill_we2", {31'd0, o_we}, 32'd0);

        do_cmd("jal_last", 3'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1,
               32'd7, 32'h008000EF, 1'b0);
        valid = 1'b0;
        check_eq("done_error_sticky", {31'd0, o_error}, 32'd1);
        tick();
        check_eq("done_hold", {31'd0, o_done}, 32'd1);

        clear_b = 1'b1;
        tick();
        clear_b = 1'b0;
        check_eq("clr_done",  {31'd0, o_done},  32'd0);
        check_eq("clr_error", {31'd0, o_error}, 32'd0);
        check_eq("clr_count", o_count, 32'd0);
        check_eq("clr_ready", {31'd0, o_ready}, 32'd1);

        do_cmd("post_clr", 3'd0, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, 21'd8, 1'b0,
               32'd0, 32'h0080A103, 1'b1);
        valid = 1'b0;

        // clear outside DONE has no effect
        clear_b = 1'b1;
        tick();
        clear_b = 1'b0;
        check_eq("clr_ignored", o_count, 32'd1);

        // small instance: fill all four words without cmd_last
        sel_small = 1'b1;
        do_cmd("s0", 3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd1, 1'b0, 32'd0, 32'h00100093, 1'b1);
        do_cmd("s1", 3'd4, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 21'd2, 1'b0, 32'd1, 32'h00200113, 1'b1);
        do_cmd("s2", 3'd4, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 21'd3, 1'b0, 32'd2, 32'h00300193, 1'b1);
        do_cmd("s3", 3'd4, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 21'd4, 1'b0, 32'd3, 32'h00400213, 1'b1 & 1'b0);
        valid = 1'b0;
        check_eq("full_count", o_count, 32'd4);
        clear_s = 1'b1;
        tick();
        clear_s = 1'b0;
        check_eq("full_clr_count", o_count, 32'd0);
        check_eq("full_clr_done", {31'd0, o_done}, 32'd0);
        do_cmd("s_wrap", 3'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 21'd1, 1'b0,
               32'd0, 32'h00100093, 1'b1);
        valid = 1'b0;
        sel_small = 1'b0;
        tick();

        // reset asserted during ENC aborts the write
        cmd_class = 3'd4; cmd_funct3 = 3'b000; cmd_rd = 5'd1; cmd_rs1 = 5'd0;
        cmd_imm = 21'd5; cmd_last = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        reset = 1'b1;
        check_eq("rmid_enc_we", {31'd0, o_we}, 32'd0);
        tick();
        reset = 1'b0;
        check_eq("rmid_we",    {31'd0, o_we},    32'd0);
        check_eq("rmid_ready", {31'd0, o_ready}, 32'd1);
        check_eq("rmid_addr",  o_addr,  32'd0);
        check_eq("rmid_wdata", o_wdata, 32'd0);
        check_eq("rmid_count", o_count, 32'd0);
        check_eq("rmid_done",  {31'd0, o_done},  32'd0);
        check_eq("rmid_error", {31'd0, o_error}, 32'd0);
        tick();
        check_eq("rmid_we2", {31'd0, o_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
